// File: rtl/add_suber.sv
// Registered two's-complement adder/subtractor with carry/zero/sign/overflow flags.
// Datapath is a two-level carry-lookahead: 4-bit CLA groups plus a group lookahead unit.
module add_suber #(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] data_A,
    input  logic [DATAWIDTH-1:0] data_B,
    input  logic                 sub_flag,
    output logic [DATAWIDTH-1:0] result,
    output logic                 co,
    output logic                 zero,
    output logic                 result_sign,
    output logic                 overflow
);

    localparam int unsigned NG = DATAWIDTH / 4;

    logic [DATAWIDTH-1:0] w_bx;
    logic [DATAWIDTH-1:0] w_g;
    logic [DATAWIDTH-1:0] w_p;
    logic [DATAWIDTH-1:0] w_sum;
    logic [NG-1:0]        w_grp_g;
    logic [NG-1:0]        w_grp_p;
    logic [NG:0]          w_grp_c;
    logic                 w_ov;

    logic [DATAWIDTH-1:0] r_result;
    logic                 r_co;
    logic                 r_zero;
    logic                 r_sign;
    logic                 r_ov;

    // Carry into group k+1: G[k] | P[k]G[k-1] | ... | P[k..0]cin, fully flattened.
    function automatic logic la_carry(input logic [NG-1:0] g, input logic [NG-1:0] p,
                                      input logic c0, input int k);
        logic c;
        logic t;
        c = c0;
        for (int j = 0; j <= k; j++) c = c & p[j];
        for (int j = 0; j <= k; j++) begin
            t = g[j];
            for (int m = j + 1; m <= k; m++) t = t & p[m];
            c = c | t;
        end
        return c;
    endfunction

    assign w_bx = data_B ^ {DATAWIDTH{sub_flag}};
    assign w_g  = data_A & w_bx;
    assign w_p  = data_A ^ w_bx;

    assign w_grp_c[0] = sub_flag;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        logic [3:0] w_gg;
        logic [3:0] w_pp;
        logic [3:0] w_c;

        assign w_gg = w_g[4*k +: 4];
        assign w_pp = w_p[4*k +: 4];

        assign w_c[0] = w_grp_c[k];
        assign w_c[1] = w_gg[0] | (w_pp[0] & w_c[0]);
        assign w_c[2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_c[0]);
        assign w_c[3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                      | (w_pp[2] & w_pp[1] & w_pp[0] & w_c[0]);

        assign w_grp_g[k] = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                          | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]);
        assign w_grp_p[k] = &w_pp;

        assign w_sum[4*k +: 4] = w_pp ^ w_c;
        assign w_grp_c[k+1]    = la_carry(w_grp_g, w_grp_p, sub_flag, k);
    end

    assign w_ov = (data_A[DATAWIDTH-1] == w_bx[DATAWIDTH-1])
               && (w_sum[DATAWIDTH-1] != data_A[DATAWIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_co     <= 1'b0;
            r_zero   <= 1'b1;
            r_sign   <= 1'b0;
            r_ov     <= 1'b0;
        end else begin
            r_result <= w_sum;
            r_co     <= w_grp_c[NG];
            r_zero   <= (w_sum == '0);
            r_sign   <= w_sum[DATAWIDTH-1];
            r_ov     <= w_ov;
        end
    end

    assign result      = r_result;
    assign co          = r_co;
    assign zero        = r_zero;
    assign result_sign = r_sign;
    assign overflow    = r_ov;

endmodule

// File: tb/tb_add_suber.sv
// Directed and randomised self-checking bench for add_suber (DATAWIDTH = 32).
// Each step drives inputs on the falling edge and checks outputs 1 ns after the next rising edge.
module tb_add_suber;

    logic        clk;
    logic        rst;
    logic [31:0] data_A;
    logic [31:0] data_B;
    logic        sub_flag;
    logic [31:0] result;
    logic        co;
    logic        zero;
    logic        result_sign;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    add_suber #(.DATAWIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_A      (data_A),
        .data_B      (data_B),
        .sub_flag    (sub_flag),
        .result      (result),
        .co          (co),
        .zero        (zero),
        .result_sign (result_sign),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
        @(negedge clk);
        rst      = r;
        data_A   = a;
        data_B   = b;
        sub_flag = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] er, input logic ec,
                         input logic ez, input logic es, input logic eo);
        logic [35:0] obs;
        logic [35:0] exp;
        obs = {result, co, zero, result_sign, overflow};
        exp = {er, ec, ez, es, eo};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed res=%h co=%b z=%b s=%b ov=%b expected res=%h co=%b z=%b s=%b ov=%b",
                   tag, obs[35:4], obs[3], obs[2], obs[1], obs[0],
                   exp[35:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [31:0] bx;
        logic [32:0] full;
        logic        mov;

        rst = 1'b1; data_A = '0; data_B = '0; sub_flag = 1'b0;

        // Reset held with nonzero operands
        step(1'b1, 32'h1234_5678, 32'h0000_0001, 1'b0);
        check("reset_hold", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("reset_hold2", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Release: first edge already carries the new result
        step(1'b0, 32'h00EE_E001, 32'h0011_1F10, 1'b0);
        check("add_basic", 32'h00FF_FF11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h00EE_E001, 32'h0011_1F10, 1'b1);
        check("sub_basic", 32'h00DD_C0F1, 1'b1, 1'b0, 1'b0, 1'b0);

        step(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("add_pos_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1);
        check("sub_neg_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);

        step(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("add_wrap", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0000_0005, 32'h0000_0005, 1'b1);
        check("sub_equal", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0000_0003, 32'h0000_0005, 1'b1);
        check("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);

        // Carry ripples across every 4-bit group boundary
        step(1'b0, 32'h0FFF_FFFF, 32'h0000_0001, 1'b0);
        check("long_carry", 32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("neg_neg_ovf", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1);
        check("zero_minus_zero", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0000_0000, 32'h0000_0001, 1'b1);
        check("zero_minus_one", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);

        // One-cycle reset mid-stream discards that cycle's operation
        step(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        check("pre_reset", 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mid_reset", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("post_reset", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);

        // Random vectors against a behavioural reference
        for (int i = 0; i < 2000; i++) begin
            ra = $urandom();
            rb = (i % 4 == 0) ? ra : 32'($urandom());
            rs = 1'($urandom_range(0, 1));
            bx = rb ^ {32{rs}};
            full = {1'b0, ra} + {1'b0, bx} + {32'b0, rs};
            mov = (ra[31] == bx[31]) && (full[31] != ra[31]);
            step(1'b0, ra, rb, rs);
            check($sformatf("rand%0d", i), full[31:0], full[32], full[31:0] == 32'h0,
                  full[31], mov);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
